// File: rtl/gemm_result_writer.sv
// GeMM result writer: buffers C-element beats and writes them row-major to SRAM.
// Optional stall counter enabled by defining GEMM_WRITER_PERF_EN.
module gemm_result_writer #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] C_base_i,
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_data_i,
  output logic                 result_ready_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef GEMM_WRITER_PERF_EN
  output logic [31:0]          stall_cycles_o,
`endif
  output logic                 overflow_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] m_q, n_q, base_q;
  logic [AddrWidth-1:0] row_q, col_q, row_base_q;
  logic [DataWidth-1:0] fifo_q [FifoDepth];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_q;

  logic run, full, empty, start_ok, zero_size;
  logic push, pop, col_last, last, flush;

  assign run       = (state_q == RUN);
  assign full      = (cnt_q == CntW'(FifoDepth));
  assign empty     = (cnt_q == '0);
  assign start_ok  = (state_q == IDLE) && start_i;
  assign zero_size = (M_size_i == '0) || (N_size_i == '0);
  assign push      = run && result_valid_i && !full;
  assign pop       = mem_req_o && mem_gnt_i;
  assign col_last  = (col_q == n_q - AddrWidth'(1));
  assign last      = pop && col_last && (row_q + AddrWidth'(1) == m_q);
  // Final grant discards any surplus beats still buffered.
  assign flush     = start_ok || last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = zero_size ? DONE : RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= result_data_i;
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop) cnt_q <= cnt_q + CntW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q        <= '0;
      n_q        <= '0;
      base_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      ovf_q      <= 1'b0;
    end else if (start_ok) begin
      m_q        <= M_size_i;
      n_q        <= N_size_i;
      base_q     <= C_base_i;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (run && result_valid_i && full) ovf_q <= 1'b1;
      if (pop) begin
        if (col_last) begin
          col_q      <= '0;
          row_q      <= row_q + AddrWidth'(1);
          row_base_q <= row_base_q + n_q;
        end else begin
          col_q <= col_q + AddrWidth'(1);
        end
      end
    end
  end

`ifdef GEMM_WRITER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (mem_req_o && !mem_gnt_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

  assign result_ready_o = run && !full;
  assign mem_req_o      = run && !empty && (row_q != m_q);
  assign mem_addr_o     = base_q + row_base_q + col_q;
  assign mem_wdata_o    = empty ? '0 : fifo_q[rptr_q];
  assign busy_o         = run;
  assign done_o         = (state_q == DONE);
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed bench for gemm_result_writer with a write scoreboard.
module tb_gemm_result_writer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] M_size_i, N_size_i, C_base_i;
  logic        result_valid_i;
  logic [31:0] result_data_i;
  logic        result_ready_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o, done_o, overflow_o;
`ifdef GEMM_WRITER_PERF_EN
  logic [31:0] stall_cycles_o;
`endif

  int ncomp = 0;
  int nfail = 0;
  int wr_count = 0;
  logic [47:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;

  gemm_result_writer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .M_size_i       (M_size_i),
    .N_size_i       (N_size_i),
    .C_base_i       (C_base_i),
    .result_valid_i (result_valid_i),
    .result_data_i  (result_data_i),
    .result_ready_o (result_ready_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
`ifdef GEMM_WRITER_PERF_EN
    .stall_cycles_o (stall_cycles_o),
`endif
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input bit ok,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    ncomp++;
    if (!ok) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    logic [47:0] e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_req", mem_req_o === 1'b1, mem_req_o, 1);
        chk("stall_addr", mem_addr_o === prev_addr,
            mem_addr_o, prev_addr);
        chk("stall_data", mem_wdata_o === prev_data,
            mem_wdata_o, prev_data);
      end
      if (mem_req_o && mem_gnt_i) begin
        chk("expected_write", exp_q.size() != 0, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr_o === e[47:32],
              mem_addr_o, e[47:32]);
          chk("wr_data", mem_wdata_o === e[31:0],
              mem_wdata_o, e[31:0]);
        end
        wr_count++;
      end
      prev_stall = mem_req_o && !mem_gnt_i;
      prev_addr  = mem_addr_o;
      prev_data  = mem_wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [15:0] m, input logic [15:0] n,
                          input logic [15:0] base);
    start_i  = 1'b1;
    M_size_i = m;
    N_size_i = n;
    C_base_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("done_seen", done_o === 1'b1, done_o, 1);
    tick();
    chk("done_one_cycle", done_o === 1'b0, done_o, 0);
    chk("idle_after_done", busy_o === 1'b0, busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    logic [15:0] a;

    rst_ni         = 1'b0;
    start_i        = 1'b0;
    M_size_i       = '0;
    N_size_i       = '0;
    C_base_i       = '0;
    result_valid_i = 1'b0;
    result_data_i  = '0;
    mem_gnt_i      = 1'b0;
    tick();
    tick();
    chk("rst_req", mem_req_o === 1'b0, mem_req_o, 0);
    chk("rst_addr", mem_addr_o === 16'h0, mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o === 32'h0, mem_wdata_o, 0);
    chk("rst_ready", result_ready_o === 1'b0, result_ready_o, 0);
    chk("rst_busy", busy_o === 1'b0, busy_o, 0);
    chk("rst_done", done_o === 1'b0, done_o, 0);
    chk("rst_ovf", overflow_o === 1'b0, overflow_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("idle_ready", result_ready_o === 1'b0, result_ready_o, 0);

    mem_gnt_i = 1'b1;
    w0 = wr_count;
    do_start(16'd2, 16'd3, 16'h0100);
    chk("t1_busy", busy_o === 1'b1, busy_o, 1);
    chk("t1_ready", result_ready_o === 1'b1, result_ready_o, 1);
    for (int i = 0; i < 6; i++) begin
      result_valid_i = 1'b1;
      result_data_i  = 32'(i + 1);
      exp_q.push_back({16'h0100 + 16'(i), 32'(i + 1)});
      tick();
    end
    result_valid_i = 1'b0;
    wait_done(n);
    chk("t1_done_latency", n === 1, n, 1);
    chk("t1_writes", (wr_count - w0) === 6, wr_count - w0, 6);
    chk("t1_ovf", overflow_o === 1'b0, overflow_o, 0);

    mem_gnt_i = 1'b0;
    w0 = wr_count;
    do_start(16'd2, 16'd2, 16'h0010);
    fork
      begin
        int idx = 0;
        int budget = 0;
        logic acc;
        while (idx < 4 && budget < 100) begin
          result_valid_i = 1'b1;
          result_data_i  = 32'(idx + 10);
          @(negedge clk_i);
          acc = result_ready_o;
          tick();
          if (acc) begin
            exp_q.push_back({16'h0010 + 16'(idx), 32'(idx + 10)});
            idx++;
          end
          budget++;
        end
        result_valid_i = 1'b0;
        chk("t2_ready_drop", result_ready_o === 1'b0,
            result_ready_o, 0);
      end
      begin
        for (int w = 0; w < 4; w++) begin
          int budget = 0;
          while (!mem_req_o && budget < 50) begin
            tick();
            budget++;
          end
          repeat (5) tick();
          mem_gnt_i = 1'b1;
          tick();
          mem_gnt_i = 1'b0;
        end
      end
    join
    wait_done(n);
    chk("t2_writes", (wr_count - w0) === 4, wr_count - w0, 4);
    chk("t2_ovf", overflow_o === 1'b0, overflow_o, 0);
`ifdef GEMM_WRITER_PERF_EN
    chk("t2_stalls", stall_cycles_o === 32'd20, stall_cycles_o, 20);
`endif

    w0 = wr_count;
    do_start(16'd2, 16'd2, 16'h0200);
    for (int i = 0; i < 5; i++) begin
      result_valid_i = 1'b1;
      result_data_i  = 32'h20 + 32'(i);
      if (i < 4) exp_q.push_back({16'h0200 + 16'(i), 32'h20 + 32'(i)});
      tick();
    end
    result_valid_i = 1'b0;
    chk("t3_ovf", overflow_o === 1'b1, overflow_o, 1);
    chk("t3_ready", result_ready_o === 1'b0, result_ready_o, 0);
    chk("t3_req", mem_req_o === 1'b1, mem_req_o, 1);
    mem_gnt_i = 1'b1;
    wait_done(n);
    chk("t3_writes", (wr_count - w0) === 4, wr_count - w0, 4);
    chk("t3_ovf_hold", overflow_o === 1'b1, overflow_o, 1);

    w0 = wr_count;
    do_start(16'd0, 16'd5, 16'h0400);
    chk("t4_done", done_o === 1'b1, done_o, 1);
    chk("t4_ovf_clr", overflow_o === 1'b0, overflow_o, 0);
    chk("t4_busy", busy_o === 1'b0, busy_o, 0);
    tick();
    chk("t4_done_end", done_o === 1'b0, done_o, 0);
    tick();
    chk("t4_req", mem_req_o === 1'b0, mem_req_o, 0);
    chk("t4_writes", (wr_count - w0) === 0, wr_count - w0, 0);

    w0 = wr_count;
    do_start(16'd1, 16'd4, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      result_valid_i = 1'b1;
      result_data_i  = 32'h50 + 32'(i);
      exp_q.push_back({a, 32'h50 + 32'(i)});
      tick();
    end
    result_valid_i = 1'b0;
    wait_done(n);
    chk("t5_done_latency", n === 1, n, 1);
    chk("t5_writes", (wr_count - w0) === 4, wr_count - w0, 4);

    w0 = wr_count;
    do_start(16'd2, 16'd3, 16'h0040);
    for (int i = 0; i < 6; i++) begin
      result_valid_i = 1'b1;
      result_data_i  = 32'h60 + 32'(i);
      exp_q.push_back({16'h0040 + 16'(i), 32'h60 + 32'(i)});
      tick();
      if (wr_count - w0 == 3) break;
    end
    rst_ni = 1'b0;
    result_valid_i = 1'b0;
    chk("t6_writes_before_rst", (wr_count - w0) === 3,
        wr_count - w0, 3);
    exp_q.delete();
    #1;
    chk("t6_rst_req", mem_req_o === 1'b0, mem_req_o, 0);
    chk("t6_rst_addr", mem_addr_o === 16'h0, mem_addr_o, 0);
    chk("t6_rst_wdata", mem_wdata_o === 32'h0, mem_wdata_o, 0);
    chk("t6_rst_ready", result_ready_o === 1'b0, result_ready_o, 0);
    chk("t6_rst_busy", busy_o === 1'b0, busy_o, 0);
    chk("t6_rst_done", done_o === 1'b0, done_o, 0);
    chk("t6_rst_ovf", overflow_o === 1'b0, overflow_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    w0 = wr_count;
    do_start(16'd1, 16'd2, 16'h0300);
    for (int i = 0; i < 2; i++) begin
      result_valid_i = 1'b1;
      result_data_i  = 32'h70 + 32'(i);
      exp_q.push_back({16'h0300 + 16'(i), 32'h70 + 32'(i)});
      tick();
    end
    result_valid_i = 1'b0;
    wait_done(n);
    chk("t6_done_latency", n === 1, n, 1);
    chk("t6_writes", (wr_count - w0) === 2, wr_count - w0, 2);
    chk("queue_drained", exp_q.size() === 0, exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

endmodule
